// File: rtl/mem_access_unit.sv
// Word-only memory adapter for the MEM stage: sub-word load extract/extend,
// sub-word store read-modify-write, misalignment flagging.
module mem_access_unit #(
    parameter bit BIG_ENDIAN   = 1'b1,
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_in,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_signed_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        req_ready_out,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        misalign_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_writedata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_readdata_in
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    logic [2:0]  r_state;
    logic [31:0] r_addr_q;
    logic [1:0]  r_size_q;
    logic        r_we_q;
    logic        r_sgn_q;
    logic [31:0] r_wdata_q;
    logic [31:0] r_merged_q;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_misalign;

    logic        w_accept;
    logic        w_mis;
    logic [31:0] w_addr_al;
    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic [31:0] w_lane_mask;
    logic [31:0] w_merged;

    assign req_ready_out = (r_state == S_IDLE);
    assign w_accept      = req_valid_in && req_ready_out;

    // Reserved size is always an error; alignment faults only in strict mode.
    always_comb begin
        w_mis     = 1'b0;
        w_addr_al = req_addr_in;
        unique case (req_size_in)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: begin
                w_mis     = STRICT_ALIGN && req_addr_in[0];
                w_addr_al = {req_addr_in[31:1], 1'b0};
            end
            SZ_WORD: begin
                w_mis     = STRICT_ALIGN && (req_addr_in[1:0] != 2'b00);
                w_addr_al = {req_addr_in[31:2], 2'b00};
            end
            default: w_mis = 1'b1;
        endcase
    end

    // Bit position of the addressed lane within the memory word.
    always_comb begin
        w_shift = 5'd0;
        if (r_size_q == SZ_BYTE) begin
            w_shift = BIG_ENDIAN ? {~r_addr_q[1:0], 3'b000}
                                 : {r_addr_q[1:0], 3'b000};
        end else if (r_size_q == SZ_HALF) begin
            w_shift = BIG_ENDIAN ? {~r_addr_q[1], 4'b0000}
                                 : {r_addr_q[1], 4'b0000};
        end
    end

    assign w_lane = mem_readdata_in >> w_shift;

    always_comb begin
        w_ext = mem_readdata_in;
        if (r_size_q == SZ_BYTE) begin
            w_ext = {{24{r_sgn_q & w_lane[7]}}, w_lane[7:0]};
        end else if (r_size_q == SZ_HALF) begin
            w_ext = {{16{r_sgn_q & w_lane[15]}}, w_lane[15:0]};
        end
    end

    assign w_lane_mask = (r_size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign w_merged    = (mem_readdata_in & ~(w_lane_mask << w_shift))
                       | ((r_wdata_q & w_lane_mask) << w_shift);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr_q     <= 32'd0;
            r_size_q     <= 2'b00;
            r_we_q       <= 1'b0;
            r_sgn_q      <= 1'b0;
            r_wdata_q    <= 32'd0;
            r_merged_q   <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_misalign   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr_q  <= w_addr_al;
                        r_size_q  <= req_size_in;
                        r_we_q    <= req_we_in;
                        r_sgn_q   <= req_signed_in;
                        r_wdata_q <= req_wdata_in;
                        if (w_mis) begin
                            r_state <= S_ERR;
                        end else if (!req_we_in) begin
                            r_state <= S_LOAD;
                        end else if (req_size_in == SZ_WORD) begin
                            r_state <= S_STORE;
                        end else begin
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_ext;
                    r_state      <= S_IDLE;
                end
                S_STORE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= 32'd0;
                    r_state      <= S_IDLE;
                end
                S_RMW_RD: begin
                    r_merged_q <= w_merged;
                    r_state    <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= 32'd0;
                    r_state      <= S_IDLE;
                end
                S_ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= 32'd0;
                    r_misalign   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid_out = r_resp_valid;
    assign resp_rdata_out = r_resp_rdata;
    assign misalign_out   = r_misalign;
    assign mem_size_out   = SZ_WORD;
    assign mem_re_out     = (r_state == S_LOAD) || (r_state == S_RMW_RD);
    assign mem_we_out     = (r_state == S_STORE) || (r_state == S_RMW_WR);
    assign mem_addr_out   = (r_state != S_IDLE) ? {r_addr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_writedata_out = 32'd0;
        if (r_state == S_STORE) begin
            mem_writedata_out = r_wdata_q;
        end else if (r_state == S_RMW_WR) begin
            mem_writedata_out = r_merged_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences and random
// traffic against a byte-array reference memory.
module tb_mem_access_unit;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clock;
    logic        reset;
    logic        req_valid_in;
    logic        req_we_in;
    logic [1:0]  req_size_in;
    logic        req_signed_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        req_ready_out;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        misalign_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_writedata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic [31:0] mem_readdata_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [16];
    logic [7:0]  rb  [64];

    mem_access_unit #(.BIG_ENDIAN(1'b1), .STRICT_ALIGN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid_in(req_valid_in), .req_we_in(req_we_in),
        .req_size_in(req_size_in), .req_signed_in(req_signed_in),
        .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_rdata_out(resp_rdata_out), .misalign_out(misalign_out),
        .mem_addr_out(mem_addr_out), .mem_writedata_out(mem_writedata_out),
        .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
        .mem_size_out(mem_size_out), .mem_readdata_in(mem_readdata_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_readdata_in = mem[mem_addr_out[5:2]];
    always @(posedge clock) begin
        if (mem_we_out) mem[mem_addr_out[5:2]] <= mem_writedata_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
    endfunction

    // Reference: big-endian byte memory, byte at lowest address is most significant.
    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic mis,
                                  output int lat, output logic [31:0] wword);
        int n;
        int off;
        off   = int'(a[5:0]);
        mis   = (sz == 2'b10) || (sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
        n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        rd    = 32'd0;
        wword = 32'd0;
        lat   = 2;
        if (mis) return;
        if (!we) begin
            for (int i = 0; i < n; i++) rd = (rd << 8) | 32'(rb[off + i]);
            if (sg && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
        end else begin
            for (int i = 0; i < n; i++) rb[off + i] = 8'(wd >> (8*(n-1-i)));
            lat   = (n == 4) ? 2 : 3;
            wword = word_of(off / 4);
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic em, input int el,
                          input logic [31:0] ewd, input string nm);
        int n;
        int nre;
        int nwe;
        int nboth;
        logic [31:0] gotwd;
        bit done;
        @(negedge clock);
        n = 0;
        while (!req_ready_out && n < 10) begin
            @(negedge clock);
            n++;
        end
        req_valid_in = 1'b1; req_we_in = we; req_size_in = sz;
        req_signed_in = sg; req_addr_in = a; req_wdata_in = wd;
        @(posedge clock);
        #1 req_valid_in = 1'b0;
        n = 0; nre = 0; nwe = 0; nboth = 0; gotwd = 32'd0; done = 1'b0;
        for (int c = 1; c <= 10 && !done; c++) begin
            if (resp_valid_out) begin
                done = 1'b1;
                n = c;
            end else begin
                if (mem_re_out) nre++;
                if (mem_we_out) begin nwe++; gotwd = mem_writedata_out; end
                if (mem_re_out && mem_we_out) nboth++;
                @(posedge clock);
                #1;
            end
        end
        if (!done) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, " latency"}, 32'(n), 32'(el));
        chk({nm, " rdata"}, resp_rdata_out, er);
        chk({nm, " misalign"}, 32'(misalign_out), 32'(em));
        chk({nm, " re_count"}, 32'(nre), (!em && (!we || sz != 2'b11)) ? 32'd1 : 32'd0);
        chk({nm, " we_count"}, 32'(nwe), (!em && we) ? 32'd1 : 32'd0);
        chk({nm, " re_we_overlap"}, 32'(nboth), 32'd0);
        if (we && !em) chk({nm, " wdata"}, gotwd, ewd);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        em;
        int          el;
        logic [31:0] ewd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic em, input int el,
                                input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
        v.er = er; v.em = em; v.el = el; v.ewd = ewd;
        return v;
    endfunction

    vec_t tv [17];

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;
        logic [31:0] ww;
        int          nresp;

        tv[0]  = mk(0, 2'b00, 1, B + 4,  0,            32'hFFFF_FF88, 0, 2, 0);
        tv[1]  = mk(0, 2'b00, 0, B + 7,  0,            32'h0000_00BB, 0, 2, 0);
        tv[2]  = mk(0, 2'b01, 1, B + 6,  0,            32'hFFFF_AABB, 0, 2, 0);
        tv[3]  = mk(0, 2'b01, 0, B + 4,  0,            32'h0000_8899, 0, 2, 0);
        tv[4]  = mk(0, 2'b11, 0, B + 4,  0,            32'h8899_AABB, 0, 2, 0);
        tv[5]  = mk(1, 2'b00, 0, B + 5,  32'h12,       32'h0,         0, 3, 32'h8812_AABB);
        tv[6]  = mk(0, 2'b11, 0, B + 4,  0,            32'h8812_AABB, 0, 2, 0);
        tv[7]  = mk(0, 2'b11, 0, B + 2,  0,            32'h0,         1, 2, 0);
        tv[8]  = mk(0, 2'b01, 1, B + 5,  0,            32'h0,         1, 2, 0);
        tv[9]  = mk(0, 2'b10, 0, B + 4,  0,            32'h0,         1, 2, 0);
        tv[10] = mk(1, 2'b11, 0, B + 8,  32'hDEAD_BEEF, 32'h0,        0, 2, 32'hDEAD_BEEF);
        tv[11] = mk(0, 2'b11, 0, B + 8,  0,            32'hDEAD_BEEF, 0, 2, 0);
        tv[12] = mk(1, 2'b01, 0, B + 10, 32'hFFFF_1234, 32'h0,        0, 3, 32'hDEAD_1234);
        tv[13] = mk(0, 2'b11, 0, B + 8,  0,            32'hDEAD_1234, 0, 2, 0);
        tv[14] = mk(0, 2'b01, 1, B + 8,  0,            32'hFFFF_DEAD, 0, 2, 0);
        tv[15] = mk(0, 2'b00, 0, B + 9,  0,            32'h0000_00AD, 0, 2, 0);
        tv[16] = mk(1, 2'b10, 0, B + 13, 32'h5A5A_5A5A, 32'h0,        1, 2, 0);

        for (int i = 0; i < 64; i++) rb[i] = 8'($urandom);
        rb[4] = 8'h88; rb[5] = 8'h99; rb[6] = 8'hAA; rb[7] = 8'hBB;
        for (int w = 0; w < 16; w++) mem[w] = word_of(w);

        reset = 1'b1;
        req_valid_in = 1'b0; req_we_in = 1'b0; req_size_in = 2'b00;
        req_signed_in = 1'b0; req_addr_in = 32'd0; req_wdata_in = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst ready", 32'(req_ready_out), 32'd1);
        chk("rst resp_valid", 32'(resp_valid_out), 32'd0);
        chk("rst rdata", resp_rdata_out, 32'd0);
        chk("rst mem_addr", mem_addr_out, 32'd0);
        chk("rst re_we", {30'd0, mem_re_out, mem_we_out}, 32'd0);
        chk("rst mem_size", 32'(mem_size_out), 32'd3);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            model(tv[i].we, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd, rd, mis, lat, ww);
            do_req(tv[i].we, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd,
                   tv[i].er, tv[i].em, tv[i].el, tv[i].ewd, $sformatf("vec%0d", i));
        end

        // Store then load held valid: load must be taken in the store's resp cycle.
        model(1, 2'b11, 0, B + 16, 32'hCAFE_F00D, rd, mis, lat, ww);
        @(negedge clock);
        req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b11;
        req_addr_in = B + 16; req_wdata_in = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        chk("b2b ready_low", 32'(req_ready_out), 32'd0);
        req_we_in = 1'b0;
        @(posedge clock);
        #1;
        chk("b2b sw_resp", 32'(resp_valid_out), 32'd1);
        chk("b2b ready_in_resp", 32'(req_ready_out), 32'd1);
        @(posedge clock);
        #1;
        chk("b2b lw_accepted", {30'd0, req_ready_out, mem_re_out}, 32'd1);
        req_valid_in = 1'b0;
        @(posedge clock);
        #1;
        chk("b2b lw_resp", 32'(resp_valid_out), 32'd1);
        chk("b2b lw_rdata", resp_rdata_out, 32'hCAFE_F00D);

        // Reset during the read half of a half-word RMW.
        @(negedge clock);
        req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b01;
        req_addr_in = B + 4; req_wdata_in = 32'h5555;
        @(posedge clock);
        #1;
        req_valid_in = 1'b0;
        chk("rstmid rmw_rd_re", 32'(mem_re_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid ready", 32'(req_ready_out), 32'd1);
        chk("rstmid re_we", {30'd0, mem_re_out, mem_we_out}, 32'd0);
        chk("rstmid mem_addr", mem_addr_out, 32'd0);
        chk("rstmid resp", {30'd0, resp_valid_out, misalign_out}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        nresp = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (resp_valid_out || mem_we_out) nresp++;
        end
        chk("rstmid no_resp_no_write", 32'(nresp), 32'd0);
        chk("rstmid word_kept", mem[1], word_of(1));

        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [1:0]  sz;
            logic        sg;
            logic [31:0] a;
            logic [31:0] wd;
            we = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            a  = B + 32'($urandom_range(0, 63));
            wd = $urandom;
            model(we, sz, sg, a, wd, rd, mis, lat, ww);
            do_req(we, sz, sg, a, wd, rd, mis, lat, ww, $sformatf("rnd%0d", i));
        end

        @(negedge clock);
        for (int w = 0; w < 16; w++) chk($sformatf("final_mem%0d", w), mem[w], word_of(w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
